// File: rtl/picomips_pkg.sv
// Shared picoMIPS types.
//   inport_state_t : states of the inport conditioner handshake FSM.
package picomips_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    FULL         = 2'd1,
    WAIT_RELEASE = 2'd2
  } inport_state_t;

endpackage

// File: rtl/global_parameters.sv
// Global build parameters shared across the picoMIPS design.
//   DATA_BUS_SIZE : width of the data bus, switch bus and inport word.
`ifndef GLOBAL_PARAMETERS_SV
`define GLOBAL_PARAMETERS_SV
`define DATA_BUS_SIZE 8
`endif

// File: rtl/inport_conditioner_debounce.sv
// Strobe synchroniser plus debounce counter.
//   clk   in  : system clock
//   reset in  : asynchronous, active-high reset
//   raw   in  : raw bouncy button level, asynchronous to clk
//   level out : debounced level
//   rise  out : one-cycle pulse on a debounced 0->1 change
//   fall  out : one-cycle pulse on a debounced 1->0 change
module debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   lvl_q, lvl_d;
  logic                   lvl_dly_q;
  logic                   strb_s;

  assign strb_s = sync_q[SYNC_STAGES-1];

  // Any disagreement must persist DEBOUNCE_CYCLES consecutive cycles; a single
  // agreeing cycle restarts the count, so the counter can never wrap.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (strb_s != lvl_q) begin
      if (cnt_q == CNT_MAX) lvl_d = ~lvl_q;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
    end
  end

  // Edge pulses come from registers only, so no input reaches them combinationally.
  assign level = lvl_q;
  assign rise  = lvl_q & ~lvl_dly_q;
  assign fall  = ~lvl_q & lvl_dly_q;

endmodule

// File: rtl/inport_conditioner.sv
// Conditions raw board inputs into the inport word (%1) of the picoMIPS register file.
//   clk        in  : system clock
//   reset      in  : asynchronous, active-high reset
//   sw         in  : raw data switches (n bits), asynchronous
//   sw_strobe  in  : raw strobe button, active-high, bouncy
//   ack        in  : consumer has taken inport
//   inport     out : latched switch word
//   data_ready out : inport holds an unconsumed word
//   overrun    out : sticky, a press was accepted while data_ready=1
`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif

module inport_conditioner
  import picomips_pkg::*;
#(
  parameter int n               = `DATA_BUS_SIZE,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] sw,
  input  logic         sw_strobe,
  input  logic         ack,
  output logic [n-1:0] inport,
  output logic         data_ready,
  output logic         overrun
);

  logic [SYNC_STAGES-1:0][n-1:0] sw_sync_q;
  logic [n-1:0]                  sw_s;
  logic                          strb_db, press, release_p;

  inport_state_t state_q, state_d;
  logic [n-1:0]  inport_q, inport_d;
  logic          rdy_q, rdy_d;
  logic          ovr_q, ovr_d;

  assign sw_s = sw_sync_q[SYNC_STAGES-1];

  debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .clk  (clk),
    .reset(reset),
    .raw  (sw_strobe),
    .level(strb_db),
    .rise (press),
    .fall (release_p)
  );

  // State register (with the datapath registers it controls).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync_q <= '0;
      state_q   <= IDLE;
      inport_q  <= '0;
      rdy_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sw_sync_q <= {sw_sync_q[SYNC_STAGES-2:0], sw};
      state_q   <= state_d;
      inport_q  <= inport_d;
      rdy_q     <= rdy_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    inport_d = inport_q;
    rdy_d    = rdy_q;
    ovr_d    = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          inport_d = sw_s;
          rdy_d    = 1'b1;
          state_d  = FULL;
        end
      end
      FULL: begin
        // A press here is always an overrun, even when ack lands in the same cycle.
        if (press) ovr_d = 1'b1;
        if (ack) begin
          rdy_d   = 1'b0;
          state_d = strb_db ? WAIT_RELEASE : IDLE;
        end
      end
      WAIT_RELEASE: begin
        if (release_p) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are straight register copies.
  always_comb begin
    inport     = inport_q;
    data_ready = rdy_q;
    overrun    = ovr_q;
  end

endmodule

// File: tb/tb_inport_conditioner.sv
module tb_inport_conditioner;
  import picomips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic       sw_strobe;
  logic       ack;
  logic [7:0] inport;
  logic       data_ready;
  logic       overrun;

  int n_chk = 0;
  int n_err = 0;

  inport_conditioner #(.n(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .sw_strobe (sw_strobe),
    .ack       (ack),
    .inport    (inport),
    .data_ready(data_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance k rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; sw = 8'hA5; sw_strobe = 1'b0; ack = 1'b0;

    // 1: reset holds all outputs at zero.
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_inport", inport, 8'h00);
      chk("rst_rdy", data_ready, 1'b0);
      chk("rst_ovr", overrun, 1'b0);
      tick(1);
    end
    reset = 1'b0;
    tick(10);
    chk("idle_inport", inport, 8'h00);
    chk("idle_rdy", data_ready, 1'b0);

    // 2: clean press; capture lands exactly on edge 7.
    sw = 8'h3C; sw_strobe = 1'b1;
    tick(6);
    chk("press_e6_rdy", data_ready, 1'b0);
    tick(1);
    chk("press_e7_rdy", data_ready, 1'b1);
    chk("press_e7_inport", inport, 8'h3C);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("ack_rdy", data_ready, 1'b0);
    chk("ack_inport", inport, 8'h3C);
    chk("ack_state", dut.state_q, WAIT_RELEASE);
    sw_strobe = 1'b0;
    tick(8);
    chk("rel_state", dut.state_q, IDLE);

    // 3: bounces shorter than the debounce window are rejected.
    sw = 8'hE7;
    for (int i = 0; i < 4; i++) begin
      sw_strobe = (i % 2 == 0);
      for (int j = 0; j < 2; j++) begin
        tick(1);
        chk("bounce_rdy", data_ready, 1'b0);
        chk("bounce_db", dut.strb_db, 1'b0);
      end
    end
    sw_strobe = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick(1);
      chk("bounce_tail_rdy", data_ready, 1'b0);
      chk("bounce_tail_db", dut.strb_db, 1'b0);
    end
    chk("bounce_inport", inport, 8'h3C);

    // 4: second press while FULL sets overrun without replacing the word.
    sw = 8'h11; sw_strobe = 1'b1;
    tick(7);
    chk("ovr_cap_rdy", data_ready, 1'b1);
    chk("ovr_cap_inport", inport, 8'h11);
    chk("ovr_pre", overrun, 1'b0);
    sw_strobe = 1'b0;
    tick(6);
    sw = 8'h22; sw_strobe = 1'b1;
    tick(6);
    chk("ovr_e6", overrun, 1'b0);
    tick(1);
    chk("ovr_e7", overrun, 1'b1);
    chk("ovr_inport", inport, 8'h11);
    chk("ovr_rdy", data_ready, 1'b1);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("ovr_ack_rdy", data_ready, 1'b0);
    chk("ovr_sticky", overrun, 1'b1);
    sw_strobe = 1'b0;
    tick(8);
    chk("ovr_sticky2", overrun, 1'b1);

    // 5: press and ack in the same cycle; ack wins, press counts as overrun.
    reset = 1'b1; tick(1); reset = 1'b0;
    chk("sim_rst_ovr", overrun, 1'b0);
    sw = 8'h11; sw_strobe = 1'b1;
    tick(7);
    chk("sim_cap", inport, 8'h11);
    sw_strobe = 1'b0;
    tick(6);
    sw = 8'h22; sw_strobe = 1'b1;
    tick(6);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("sim_rdy", data_ready, 1'b0);
    chk("sim_inport", inport, 8'h11);
    chk("sim_ovr", overrun, 1'b1);
    chk("sim_state", dut.state_q, WAIT_RELEASE);
    sw_strobe = 1'b0;
    tick(8);
    chk("sim_idle", dut.state_q, IDLE);

    // 6: async reset mid-debounce clears at once and restarts the debounce.
    sw = 8'h5A; sw_strobe = 1'b1;
    tick(7);
    chk("ar_cap", inport, 8'h5A);
    sw_strobe = 1'b0;
    tick(6);
    sw = 8'h77; sw_strobe = 1'b1;
    tick(2);
    #3 reset = 1'b1;
    #1;
    chk("ar_inport", inport, 8'h00);
    chk("ar_rdy", data_ready, 1'b0);
    chk("ar_ovr", overrun, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick(6);
    chk("ar_e6_rdy", data_ready, 1'b0);
    tick(1);
    chk("ar_e7_rdy", data_ready, 1'b1);
    chk("ar_e7_inport", inport, 8'h77);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
